// File: rtl/neuron_pkg.sv
// neuron_pkg -- shared definitions for the neuron_unit codebase slice.
//   state_t          : FSM states of the neuron controller
//   DEF_*_WIDTH      : default widths for the neuron_unit parameters
//   sat_max/sat_min  : signed saturation bounds for a given result width
//   SAT_MAX/SAT_MIN  : saturation bounds at the default result width
package neuron_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_CNT_WIDTH  = 8;
  localparam int DEF_ACC_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACT  = 2'd2,
    OUT  = 2'd3
  } state_t;

  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(DEF_DATA_WIDTH);
  localparam longint SAT_MIN = sat_min(DEF_DATA_WIDTH);

endpackage

// File: rtl/neuron_sat_act.sv
// neuron_sat_act -- combinational saturate-then-activate stage.
// Clamps the wide signed accumulator into the signed result range, then
// applies the activation function.
// Configuration macro: NEURON_RELU_EN -- when defined the activation is
// ReLU (negative results become 0); otherwise it is the identity.
// Ports:
//   acc    in  ACC_WIDTH   signed accumulator value
//   result out DATA_WIDTH  signed activated result
module neuron_sat_act
  import neuron_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic        [DATA_WIDTH-1:0] result
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(sat_min(DATA_WIDTH));

  logic [DATA_WIDTH-1:0] sat;

  // NOTE: every variable written in a combinational block gets a default
  // assignment first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sat = acc[DATA_WIDTH-1:0];
    if (acc > MAX_V) begin
      sat = MAX_V[DATA_WIDTH-1:0];
    end else if (acc < MIN_V) begin
      sat = MIN_V[DATA_WIDTH-1:0];
    end
`ifdef NEURON_RELU_EN
    result = sat[DATA_WIDTH-1] ? '0 : sat;
`else
    result = sat;
`endif
  end

endmodule

// File: rtl/neuron_unit.sv
// neuron_unit -- accumulates cfg_len signed partial sums plus a bias, then
// emits one saturated, activated result per neuron.
// The activation is selected by NEURON_RELU_EN inside neuron_sat_act.
// Ports:
//   clk        in   1           clock, rising edge
//   rst        in   1           synchronous active-high reset
//   cfg_len    in   CNT_WIDTH   terms per neuron (0 behaves as 1)
//   cfg_bias   in   DATA_WIDTH  signed bias, sampled with the first term
//   in_valid   in   1           partial sum valid
//   in_ready   out  1           block accepts in_data
//   in_data    in   DATA_WIDTH  signed partial sum
//   out_valid  out  1           result valid
//   out_ready  in   1           consumer accepts the result
//   out_data   out  DATA_WIDTH  signed activated result
//   busy       out  1           a neuron is in progress (state != IDLE)
module neuron_unit
  import neuron_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] cfg_bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  // The accumulator must hold bias plus up to 2^CNT_WIDTH-1 terms without
  // wrapping, so saturation always sees the true sum.
  generate
    if (ACC_WIDTH < DATA_WIDTH + CNT_WIDTH + 1) begin : g_acc_width_check
      $error("neuron_unit: ACC_WIDTH must be >= DATA_WIDTH+CNT_WIDTH+1");
    end
  endgenerate

  state_t                       state;
  state_t                       next_state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic        [CNT_WIDTH-1:0]  cnt;
  logic        [CNT_WIDTH-1:0]  len_q;
  logic        [CNT_WIDTH-1:0]  len_eff;
  logic        [CNT_WIDTH-1:0]  cnt_inc;
  logic signed [ACC_WIDTH-1:0]  data_ext;
  logic signed [ACC_WIDTH-1:0]  bias_ext;
  logic        [DATA_WIDTH-1:0] act_result;
  logic                         in_fire;

  assign data_ext = ACC_WIDTH'($signed(in_data));
  assign bias_ext = ACC_WIDTH'($signed(cfg_bias));
  assign len_eff  = (cfg_len == '0) ? CNT_WIDTH'(1) : cfg_len;
  assign cnt_inc  = cnt + CNT_WIDTH'(1);
  assign in_fire  = in_valid && in_ready;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (in_fire) next_state = (len_eff == CNT_WIDTH'(1)) ? ACT : ACC;
      ACC:  if (in_fire && (cnt_inc == len_q)) next_state = ACT;
      ACT:  next_state = OUT;
      OUT:  if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decoded from state; all handshake outputs are forced low
  // while rst is asserted, including the cycle before the reset edge.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      in_ready  = (state == IDLE) || (state == ACC);
      out_valid = (state == OUT);
      busy      = (state != IDLE);
    end
  end

  // Datapath. The bias is folded into the accumulator with the first term,
  // so later cfg_bias changes cannot affect the neuron in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      len_q    <= '0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_fire) begin
            len_q <= len_eff;
            acc   <= bias_ext + data_ext;
            cnt   <= CNT_WIDTH'(1);
          end
        end
        ACC: begin
          if (in_fire) begin
            acc <= acc + data_ext;
            cnt <= cnt_inc;
          end
        end
        ACT: out_data <= act_result;
        OUT: ;  // out_data holds through and after the handshake
        default: ;
      endcase
    end
  end

  neuron_sat_act #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sat_act (
    .acc    (acc),
    .result (act_result)
  );

endmodule
